text_buffer_ctrl: RTL and testbench

Owns the character buffer for the VGA text overlay and arbitrates writes to it. Two producers share one write slot per cycle: a cursor-driven stream port (console style, with newline, backspace and auto-scroll) and a random-access port. The renderer reads the buffer through a registered read port. Clear and scroll sequences run as internal multi-cycle operations that stall both producers.

---
 rtl/text_buffer_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_text_buffer_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_ctrl.sv
// Character buffer for the VGA text overlay: console-style stream port, random-access port,
// registered renderer read port, and internal multi-cycle clear/scroll sequences.
module text_buffer_ctrl #(
  parameter int COLS   = 21,
  parameter int ROWS   = 12,
  parameter int ADDR_W = 9
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              cVS,
  input  logic              frame_lock,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [7:0]        s0_char,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [7:0]        s1_char,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_char,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  localparam int N     = COLS * ROWS;
  localparam int IDX_W = $clog2(N);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [ADDR_W-1:0] N_A       = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LASTROW_A = ADDR_W'(N - COLS);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_SCROLL = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem_q [N];
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              rr_q, rr_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic [7:0]        rd_q;

  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [7:0]        wdata;
  logic              can_xfer, go0, go1;
  logic [IDX_W-1:0]  src_idx;
  logic [ADDR_W-1:0] cur_dec;

  // Handshake: a word moves on a rising edge where valid && ready. Ready is combinational and
  // never depends on the transfer itself; with both ports valid exactly one ready is high.
  assign can_xfer = iRST_n && (state_q == S_IDLE) && !clr_req && !pend_q &&
                    (!frame_lock || !cVS);
  assign s0_ready = can_xfer && (!rr_q || !s1_valid);
  assign s1_ready = can_xfer && (rr_q || !s0_valid);
  assign go0      = s0_valid && s0_ready;
  assign go1      = s1_valid && s1_ready;

  assign src_idx = cnt_q[IDX_W-1:0] + IDX_W'(COLS);
  assign cur_dec = cursor_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cursor_d = cursor_q;
    col_d    = col_q;
    row_d    = row_q;
    rr_d     = rr_q;
    pend_d   = pend_q;
    err_d    = 1'b0;
    we       = 1'b0;
    waddr    = cursor_q[IDX_W-1:0];
    wdata    = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (clr_req || pend_q) begin
          state_d  = S_CLEAR;
          cnt_d    = '0;
          cursor_d = '0;
          col_d    = '0;
          row_d    = '0;
          pend_d   = 1'b0;
        end else if (go0) begin
          rr_d = ~rr_q;
          if (s0_char >= 8'h20 && s0_char <= 8'h7E) begin
            we    = 1'b1;
            wdata = s0_char;
            if (cursor_q == LAST_A) begin
              state_d = S_SCROLL;
              cnt_d   = '0;
            end else begin
              cursor_d = cursor_q + 1'b1;
              if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
          end else if (s0_char == 8'h0A) begin
            if (row_q == LAST_ROW) begin
              state_d = S_SCROLL;
              cnt_d   = '0;
            end else begin
              cursor_d = cursor_q + COLS_A - ADDR_W'(col_q);
              col_d    = '0;
              row_d    = row_q + 1'b1;
            end
          end else if (s0_char == 8'h08 && cursor_q != '0) begin
            we       = 1'b1;
            waddr    = cur_dec[IDX_W-1:0];
            cursor_d = cur_dec;
            if (col_q == '0) begin
              col_d = LAST_COL;
              row_d = row_q - 1'b1;
            end else begin
              col_d = col_q - 1'b1;
            end
          end
        end else if (go1) begin
          rr_d = ~rr_q;
          if (s1_addr < N_A) begin
            we    = 1'b1;
            waddr = s1_addr[IDX_W-1:0];
            wdata = s1_char;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q[IDX_W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_A) state_d = S_IDLE;
      end
      S_SCROLL: begin
        we    = 1'b1;
        waddr = cnt_q[IDX_W-1:0];
        wdata = (cnt_q < LASTROW_A) ? mem_q[src_idx] : 8'h00;
        cnt_d = cnt_q + 1'b1;
        if (clr_req) pend_d = 1'b1;
        // A clear requested mid-scroll starts on the same edge the scroll finishes.
        if (cnt_q == LAST_A) begin
          cnt_d = '0;
          if (clr_req || pend_q) begin
            state_d  = S_CLEAR;
            cursor_d = '0;
            col_d    = '0;
            row_d    = '0;
            pend_d   = 1'b0;
          end else begin
            state_d  = S_IDLE;
            cursor_d = LASTROW_A;
            col_d    = '0;
            row_d    = LAST_ROW;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cursor_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      rr_q     <= 1'b0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 8'h00;
      for (int i = 0; i < N; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cursor_q <= cursor_d;
      col_q    <= col_d;
      row_q    <= row_d;
      rr_q     <= rr_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      // Sampled before this edge's write lands, so the renderer sees read-before-write data.
      rd_q     <= (rd_addr < N_A) ? mem_q[rd_addr[IDX_W-1:0]] : 8'h00;
      if (we) mem_q[waddr] <= wdata;
    end
  end

  assign rd_char     = rd_q;
  assign cursor      = cursor_q;
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Bench for text_buffer_ctrl: directed scenarios plus random traffic against a whole-array
// behavioural model of the character buffer.
module tb_text_buffer_ctrl;
  localparam int COLS   = 21;
  localparam int ROWS   = 12;
  localparam int ADDR_W = 9;
  localparam int N      = COLS * ROWS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cvs = 1'b0, fl = 1'b0, clr = 1'b0;
  logic              s0v = 1'b0, s1v = 1'b0;
  logic [7:0]        s0c = 8'h00, s1c = 8'h00;
  logic [ADDR_W-1:0] s1a = '0, rda = '0;
  logic              s0_ready, s1_ready, busy, err;
  logic [7:0]        rd_char;
  logic [ADDR_W-1:0] cursor;
  logic [1:0]        dbg_state;

  text_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .cVS(cvs), .frame_lock(fl),
    .s0_valid(s0v), .s0_ready(s0_ready), .s0_char(s0c),
    .s1_valid(s1v), .s1_ready(s1_ready), .s1_addr(s1a), .s1_char(s1c),
    .clr_req(clr), .rd_addr(rda), .rd_char(rd_char), .cursor(cursor),
    .busy(busy), .err(err), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: array image, cursor, remaining busy cycles, current operation, pending clear, pointer.
  logic [7:0] m_mem [N];
  int         m_cur, m_rem, m_op, m_pend, m_ptr;
  logic       m_err;
  logic [7:0] exp_q [$];

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_mem[k] = 8'h00;
    m_cur = 0; m_rem = 0; m_op = 0; m_pend = 0; m_ptr = 0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic m_clear();
    for (int k = 0; k < N; k++) m_mem[k] = 8'h00;
    m_cur = 0; m_rem = N; m_op = 1; m_pend = 0;
  endtask

  task automatic m_scroll();
    for (int k = 0; k < N; k++) m_mem[k] = (k < N - COLS) ? m_mem[k + COLS] : 8'h00;
    m_rem = N; m_op = 2;
  endtask

  task automatic m_stream(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_mem[m_cur] = c;
      if (m_cur == N - 1) m_scroll();
      else m_cur++;
    end else if (c == 8'h0A) begin
      if (m_cur / COLS == ROWS - 1) m_scroll();
      else m_cur = (m_cur / COLS + 1) * COLS;
    end else if (c == 8'h08 && m_cur > 0) begin
      m_cur--;
      m_mem[m_cur] = 8'h00;
    end
  endtask

  // One clock: check readys against the model, step the model on the edge, check outputs after.
  task automatic tick();
    logic can, r0e, r1e, x0, x1, chk_rd;
    logic [7:0] rd_e, e;
    #1;
    can = rst_n && (m_rem == 0) && !clr && (m_pend == 0) && (!fl || !cvs);
    r0e = can; r1e = can;
    if (s0v && s1v) begin
      r0e = can && (m_ptr == 0);
      r1e = can && (m_ptr == 1);
    end
    x0 = 1'b0; x1 = 1'b0;
    if (s0v) begin
      n_vec++;
      if (s0_ready !== r0e) begin
        n_err++;
        $display("FAIL s0_ready: got %b expected %b at %0t", s0_ready, r0e, $time);
      end
      x0 = r0e;
    end
    if (s1v) begin
      n_vec++;
      if (s1_ready !== r1e) begin
        n_err++;
        $display("FAIL s1_ready: got %b expected %b at %0t", s1_ready, r1e, $time);
      end
      x1 = r1e;
    end
    @(posedge clk);
    chk_rd = (m_rem == 0);
    rd_e = (rda < N) ? m_mem[rda] : 8'h00;
    m_err = 1'b0;
    if (m_rem > 0) begin
      m_rem--;
      if (m_op == 2 && clr) m_pend = 1;
      if (m_rem == 0) begin
        if (m_op == 2 && m_pend != 0) m_clear();
        else begin
          if (m_op == 2) m_cur = N - COLS;
          m_op = 0;
        end
      end
    end else if (clr || m_pend != 0) begin
      m_clear();
    end else if (x0) begin
      m_ptr ^= 1;
      m_stream(s0c);
    end else if (x1) begin
      m_ptr ^= 1;
      if (s1a < N) m_mem[s1a] = s1c;
      else m_err = 1'b1;
    end
    if (chk_rd) exp_q.push_back(rd_e);
    @(negedge clk);
    n_vec++;
    if (busy !== (m_rem > 0)) begin
      n_err++;
      $display("FAIL busy: got %b expected %b at %0t", busy, (m_rem > 0), $time);
    end
    n_vec++;
    if (err !== m_err) begin
      n_err++;
      $display("FAIL err: got %b expected %b at %0t", err, m_err, $time);
    end
    if (m_rem == 0) begin
      n_vec++;
      if (cursor !== ADDR_W'(m_cur)) begin
        n_err++;
        $display("FAIL cursor: got %0d expected %0d at %0t", cursor, m_cur, $time);
      end
    end
    if (chk_rd) begin
      e = exp_q.pop_front();
      n_vec++;
      if (rd_char !== e) begin
        n_err++;
        $display("FAIL rd_char: got %02h expected %02h at %0t", rd_char, e, $time);
      end
    end
  endtask

  task automatic idle_inputs();
    s0v = 1'b0; s1v = 1'b0; clr = 1'b0;
  endtask

  task automatic check_all();
    idle_inputs();
    for (int a = 0; a < N; a++) begin
      rda = ADDR_W'(a);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    s0v = 1'b1; s1v = 1'b1;
    for (int r = 0; r < 2; r++) begin
      #1;
      n_vec += 6;
      if (s0_ready !== 1'b0) begin n_err++; $display("FAIL reset_s0_ready: got %b expected 0", s0_ready); end
      if (s1_ready !== 1'b0) begin n_err++; $display("FAIL reset_s1_ready: got %b expected 0", s1_ready); end
      if (rd_char !== 8'h00) begin n_err++; $display("FAIL reset_rd_char: got %02h expected 00", rd_char); end
      if (cursor !== '0)     begin n_err++; $display("FAIL reset_cursor: got %0d expected 0", cursor); end
      if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (err !== 1'b0)      begin n_err++; $display("FAIL reset_err: got %b expected 0", err); end
      repeat (2) @(negedge clk);
    end
    idle_inputs();
    fl = 1'b0; cvs = 1'b0; rda = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_hi();
    s0v = 1'b1;
    s0c = 8'h48; tick();
    s0c = 8'h69; tick();
    s0v = 1'b0;
    rda = 9'd1; tick();
    n_vec += 2;
    if (rd_char !== 8'h69) begin n_err++; $display("FAIL hi_cell1: got %02h expected 69", rd_char); end
    if (cursor !== 9'd2)   begin n_err++; $display("FAIL hi_cursor: got %0d expected 2", cursor); end
    rda = 9'd0; tick();
    n_vec++;
    if (rd_char !== 8'h48) begin n_err++; $display("FAIL hi_cell0: got %02h expected 48", rd_char); end
  endtask

  task automatic test_arbitration();
    logic exp0;
    test_reset();
    s0v = 1'b1; s1v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0c = 8'h41 + 8'(i);
      s1a = ADDR_W'(100 + i);
      s1c = 8'h30 + 8'(i);
      exp0 = (i % 2 == 0);
      #1;
      n_vec += 2;
      if (s0_ready !== exp0)  begin n_err++; $display("FAIL arb_s0_grant%0d: got %b expected %b", i, s0_ready, exp0); end
      if (s1_ready !== !exp0) begin n_err++; $display("FAIL arb_s1_grant%0d: got %b expected %b", i, s1_ready, !exp0); end
      tick();
    end
    check_all();
  endtask

  task automatic test_bad_addr();
    s1v = 1'b1; s1a = ADDR_W'(N); s1c = 8'h55;
    tick();
    n_vec++;
    if (err !== 1'b1) begin n_err++; $display("FAIL bad_addr_err: got %b expected 1", err); end
    s1a = 9'd10; s1c = 8'h7A;
    #1;
    n_vec++;
    if (s1_ready !== 1'b1) begin n_err++; $display("FAIL bad_addr_ready: got %b expected 1", s1_ready); end
    tick();
    n_vec++;
    if (err !== 1'b0) begin n_err++; $display("FAIL bad_addr_err_drop: got %b expected 0", err); end
    idle_inputs();
    rda = 9'd10; tick(); tick();
  endtask

  task automatic test_scroll();
    int busy_cnt;
    idle_inputs();
    s1v = 1'b1;
    for (int k = 0; k < N; k++) begin
      s1a = ADDR_W'(k);
      s1c = 8'($urandom_range(32, 126));
      tick();
    end
    s1v = 1'b0;
    s0v = 1'b1; s0c = 8'h0A;
    for (int r = 0; r < ROWS && (m_cur / COLS) < ROWS - 1; r++) tick();
    n_vec++;
    if (cursor !== ADDR_W'(N - COLS)) begin n_err++; $display("FAIL scroll_pre_cursor: got %0d expected %0d", cursor, N - COLS); end
    tick();
    s0v = 1'b0;
    busy_cnt = busy ? 1 : 0;
    for (int c = 0; c < N + 4; c++) begin
      tick();
      if (busy) busy_cnt++;
    end
    n_vec += 2;
    if (busy_cnt != N) begin n_err++; $display("FAIL scroll_busy_len: got %0d expected %0d", busy_cnt, N); end
    if (cursor !== ADDR_W'(N - COLS)) begin n_err++; $display("FAIL scroll_cursor: got %0d expected %0d", cursor, N - COLS); end
    check_all();
  endtask

  task automatic test_scroll_clear();
    int busy_cnt;
    s0v = 1'b1;
    s0c = 8'h78; tick();
    s0c = 8'h0A; tick();
    s0v = 1'b0;
    busy_cnt = busy ? 1 : 0;
    for (int c = 0; c < 2 * N + 6; c++) begin
      clr = (c == 40);
      tick();
      if (busy) busy_cnt++;
    end
    clr = 1'b0;
    n_vec += 2;
    if (busy_cnt != 2 * N) begin n_err++; $display("FAIL scroll_clear_busy_len: got %0d expected %0d", busy_cnt, 2 * N); end
    if (cursor !== '0) begin n_err++; $display("FAIL scroll_clear_cursor: got %0d expected 0", cursor); end
    check_all();
  endtask

  task automatic test_frame_lock();
    fl = 1'b1; cvs = 1'b1;
    s0v = 1'b1; s0c = 8'h51;
    s1v = 1'b1; s1a = 9'd5; s1c = 8'h52;
    repeat (3) tick();
    #1;
    n_vec += 2;
    if (s0_ready !== 1'b0) begin n_err++; $display("FAIL lock_s0_ready: got %b expected 0", s0_ready); end
    if (s1_ready !== 1'b0) begin n_err++; $display("FAIL lock_s1_ready: got %b expected 0", s1_ready); end
    s1v = 1'b0; cvs = 1'b0;
    #1;
    n_vec++;
    if (s0_ready !== 1'b1) begin n_err++; $display("FAIL unlock_s0_ready: got %b expected 1", s0_ready); end
    tick();
    s0v = 1'b0; cvs = 1'b1;
    rda = '0; tick();
    n_vec += 2;
    if (cursor !== 9'd1)   begin n_err++; $display("FAIL lock_cursor: got %0d expected 1", cursor); end
    if (rd_char !== 8'h51) begin n_err++; $display("FAIL lock_cell0: got %02h expected 51", rd_char); end
    fl = 1'b0;
  endtask

  task automatic test_backspace();
    logic [7:0] seq [6];
    seq = '{8'h08, 8'h08, 8'h61, 8'h62, 8'h08, 8'h1B};
    s0v = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s0c = seq[i];
      tick();
    end
    s0v = 1'b0;
    n_vec++;
    if (cursor !== 9'd1) begin n_err++; $display("FAIL backspace_cursor: got %0d expected 1", cursor); end
    for (int a = 0; a < 4; a++) begin
      rda = ADDR_W'(a);
      tick();
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      s0v = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r == 0) s0c = 8'h0A;
      else if (r == 1) s0c = 8'h08;
      else if (r == 2) s0c = 8'($urandom_range(0, 255));
      else s0c = 8'($urandom_range(32, 126));
      s1v = 1'($urandom_range(0, 1));
      s1a = ADDR_W'($urandom_range(0, N + 8));
      s1c = 8'($urandom_range(0, 255));
      clr = ($urandom_range(0, 399) == 0);
      fl  = ($urandom_range(0, 3) == 0);
      cvs = 1'($urandom_range(0, 1));
      rda = ADDR_W'($urandom_range(0, N + 3));
      tick();
    end
    fl = 1'b0;
    idle_inputs();
    for (int c = 0; c < 2 * N + 2 && m_rem > 0; c++) tick();
    check_all();
  endtask

  task automatic test_reset_abort();
    idle_inputs();
    s1v = 1'b1; s1a = 9'd110; s1c = 8'h4B; tick();
    s1v = 1'b0;
    s0v = 1'b1; s0c = 8'h0A;
    for (int r = 0; r < ROWS + 1 && m_rem == 0; r++) tick();
    s0v = 1'b0;
    repeat (50) tick();
    test_reset();
    check_all();
    clr = 1'b1; tick();
    clr = 1'b0;
    repeat (30) tick();
    test_reset();
    check_all();
  endtask

  initial begin
    test_reset();
    test_hi();
    test_arbitration();
    test_bad_addr();
    test_scroll();
    test_scroll_clear();
    test_frame_lock();
    test_backspace();
    test_random();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
